gray_rr_scheduler: RTL and testbench

- Shares a single grayscale conversion unit among NUM_REQ pixel requesters, for example the camera preview path and the motion-window taps.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- The converted pixel is returned through one registered output slot, tagged with the requester ID. The output honours downstream backpressure.
- Sits between the camera/line-buffer readers and the motion-detect / VGA output stages.

---
 rtl/gray_rr_scheduler.sv | 75 +++++++
 tb/tb_gray_rr_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_rr_scheduler.sv
// rtl/gray_rr_scheduler.sv - round-robin shared RGB444-to-gray converter with one registered output slot
module gray_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gray_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*12-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [11:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic [15:0]           busy_cnt
);

  logic [ID_W-1:0] last_gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            slot_free;
  logic [11:0]     sel_pix;

  function automatic logic [11:0] to_gray(input logic [11:0] p);
    logic [11:0] sum;
    sum = 12'd77  * {8'd0, p[11:8]}
        + 12'd154 * {8'd0, p[7:4]}
        + 12'd25  * {8'd0, p[3:0]};
    return {sum[11:8], sum[11:8], sum[11:8]};
  endfunction

  assign slot_free = !rsp_valid || rsp_ready;

  // Scan starts just past the last winner so every requester is reached within NUM_REQ grants.
  always_comb begin
    int cand;
    req_ready = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    cand      = 0;
    if (!reset && slot_free) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (int'(last_gnt) + k) % NUM_REQ;
        if (!gnt_found && req_valid[ID_W'(cand)]) begin
          gnt_found = 1'b1;
          gnt_id    = ID_W'(cand);
        end
      end
    end
    if (gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign sel_pix = req_data[int'(gnt_id)*12 +: 12];

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy_cnt  <= '0;
      last_gnt  <= ID_W'(NUM_REQ - 1);
    end else if (gnt_found) begin
      // A drain and a new accept in the same cycle simply reload the slot.
      rsp_valid <= 1'b1;
      rsp_data  <= gray_en ? to_gray(sel_pix) : sel_pix;
      rsp_id    <= gnt_id;
      last_gnt  <= gnt_id;
      busy_cnt  <= busy_cnt + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_rr_scheduler.sv
// tb/tb_gray_rr_scheduler.sv - randomized and directed bench for gray_rr_scheduler against a behavioural model
module tb_gray_rr_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gray_en = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [11:0] pix [N];
  logic [N*12-1:0] req_data;
  logic [N-1:0] req_ready;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready = 1'b1;
  logic [15:0] busy_cnt;

  int checks = 0;
  int passed = 0;

  // reference state
  int m_valid = 0;
  int m_data  = 0;
  int m_id    = 0;
  int m_cnt   = 0;
  int m_last  = N - 1;
  int last_g  = -1;

  always #5 clk = ~clk;

  assign req_data = {pix[3], pix[2], pix[1], pix[0]};

  gray_rr_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .gray_en(gray_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    else passed++;
  endtask

  function automatic int gray_of(input int p, input int en);
    int y;
    if (en == 0) return p;
    y = (77 * ((p >> 8) & 15) + 154 * ((p >> 4) & 15) + 25 * (p & 15)) / 256;
    return y * 'h111;
  endfunction

  function automatic int exp_grant();
    if (reset) return -1;
    if (m_valid != 0 && !rsp_ready) return -1;
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int g;
    @(negedge clk);
    g = exp_grant();
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("busy_cnt",  32'(busy_cnt),  32'(m_cnt));
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_data = 0; m_id = 0; m_cnt = 0; m_last = N - 1;
    end else if (g >= 0) begin
      m_valid = 1; m_id = g; m_last = g;
      m_data = gray_of(int'(pix[g]), int'(gray_en));
      m_cnt = (m_cnt + 1) % 65536;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  logic [11:0] conv_in  [6] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h888, 12'h000};
  logic [11:0] conv_out [6] = '{12'hFFF, 12'h444, 12'h999, 12'h111, 12'h888, 12'h000};

  initial begin
    for (int i = 0; i < N; i++) pix[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    do_reset();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cnt", 32'(busy_cnt), 32'd0);

    // conversion table on requester 0
    gray_en = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 4'b0001; pix[0] = conv_in[i];
      cycle();
      chk("conv_data", 32'(rsp_data), 32'(conv_out[i]));
      chk("conv_id", 32'(rsp_id), 32'd0);
      chk("conv_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = '0;
    cycle();

    // round robin right after reset
    do_reset();
    for (int i = 0; i < N; i++) pix[i] = 12'($urandom);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_id", 32'(rsp_id), 32'(k % N));
    end
    chk("rr_cnt", 32'(busy_cnt), 32'd8);

    // backpressure: result of requester 3 held for 5 cycles
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_data", 32'(rsp_data), 32'(gray_of(int'(pix[3]), 1)));
      chk("bp_id", 32'(rsp_id), 32'd3);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_reload_valid", 32'(rsp_valid), 32'd1);
    chk("bp_reload_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    cycle();

    // sparse fairness with idle gaps
    do_reset();
    req_valid = 4'b0010; cycle();
    chk("sp_first", 32'(rsp_id), 32'd1);
    req_valid = '0; cycle(); cycle();
    req_valid = 4'b1010; cycle();
    chk("sp_a", 32'(rsp_id), 32'd3);
    cycle();
    chk("sp_b", 32'(rsp_id), 32'd1);
    req_valid = '0; cycle();
    req_valid = 4'b1010; cycle();
    chk("sp_c", 32'(rsp_id), 32'd3);
    req_valid = '0; cycle();

    // bypass and gray_en toggle while held
    gray_en = 1'b0; pix[0] = 12'hA5C; req_valid = 4'b0001;
    cycle();
    chk("byp_data", 32'(rsp_data), 32'hA5C);
    req_valid = '0; rsp_ready = 1'b0; gray_en = 1'b1;
    cycle(); gray_en = 1'b0; cycle();
    chk("byp_hold", 32'(rsp_data), 32'hA5C);

    // reset mid-operation with requests pending
    gray_en = 1'b1; req_valid = 4'b0101;
    reset = 1'b1;
    cycle();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cnt", 32'(busy_cnt), 32'd0);
    reset = 1'b0; rsp_ready = 1'b1;
    cycle();
    chk("mid_rst_first", 32'(rsp_id), 32'd0);

    // randomized traffic; requesters hold their pixel until granted
    req_valid = '0;
    for (int c = 0; c < 1500; c++) begin
      rsp_ready = ($urandom_range(3) != 0);
      gray_en   = 1'($urandom);
      reset     = ($urandom_range(199) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (last_g == i) begin
          req_valid[i] = 1'($urandom);
          pix[i] = 12'($urandom);
        end else if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          pix[i] = 12'($urandom);
        end
      end
    end
    reset = 1'b0;

    // busy_cnt wrap
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0001;
    for (int c = 0; c < 65535; c++) cycle();
    chk("cnt_max", 32'(busy_cnt), 32'hFFFF);
    cycle();
    chk("cnt_wrap", 32'(busy_cnt), 32'd0);
    req_valid = '0;
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
